divisor_multi: RTL and testbench
================================

# divisor_multi

Parametrised, multi-channel successor to the single fixed-ratio divider. Each of CHANNELS independent channels divides `i_clk` by a runtime-programmable ratio and emits a one-cycle tick plus a 50 % square wave. Divisor updates are staged and applied glitch-free at the channel's next wrap. The block sits beside the system clock root and feeds timers, debouncers and display-refresh logic with clock-enable ticks. It never drives a clock net.

## Interface
Parameters:
- `WIDTH`, 26: counter and divisor width.
- `CHANNELS`, 4: number of independent channels (1..16).
- `DEFAULT_DIV`, 10_000_000: divisor loaded at reset into every channel.

Ports:
- `i_clk`  in  1: the single clock; all logic on its rising edge.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_CE`  in  1: global count enable; low freezes all counters.
- `i_ch_en`  in  CHANNELS: per-channel enable.
- `i_sync`  in  1: one-cycle strobe that restarts all channels in phase.
- `i_wr`  in  1: divisor write strobe.
- `i_wr_ch`  in  $clog2(CHANNELS) (min 1): target channel of the write.
- `i_wr_div`  in  WIDTH: new divisor D; the period is D+1 cycles.
- `o_tick`  out  CHANNELS: one-cycle pulse per period.
- `o_sq`  out  CHANNELS: toggles on every tick; the period is 2(D+1).
- `o_pending`  out  CHANNELS: a staged divisor has not yet been applied.

## Operation
- Per-channel state:
  - `cnt` (WIDTH)
  - `div_act` (active divisor)
  - `div_shd` (shadow divisor)
  - `pend`
  - registered `tick` and `sq`
- Reset values:
  - `cnt`=0, `tick`=0, `sq`=0, `pend`=0.
  - `div_act`=`div_shd`=DEFAULT_DIV.
  - All outputs are 0.
- Write: `i_wr`=1 with `i_wr_ch`<CHANNELS sets `div_shd`=`i_wr_div` and `pend`=1.
  - A write with `i_wr_ch`≥CHANNELS is ignored.
  - Writes are accepted regardless of `i_CE` and `i_ch_en`.
- Counting, only when `i_CE`=1 and `i_ch_en[c]`=1:
  - If `cnt`==`div_act`: `cnt`←0, `tick`←1, `sq`←~`sq`. If `pend`, also `div_act`←`div_shd` and `pend`←0.
  - Otherwise: `cnt`←`cnt`+1, `tick`←0.
- Wrap condition: the comparison is equality, not `<=`, so the period is exactly D+1. D=0 gives a tick every enabled cycle and `sq` toggling every cycle.
- `i_CE`=0: `cnt`, `sq` and `div_act` hold; `tick`←0. A tick never stretches beyond one cycle.
- `i_ch_en[c]`=0: `cnt`←0, `tick`←0, `sq`←0. A pending shadow is applied immediately.
- `i_sync`=1: all channels get `cnt`←0, `tick`←0, `sq`←0, and any pending shadow is applied. `i_sync` overrides `i_CE` and counting.
- Simultaneous events:
  - Write coincident with that channel's wrap or `i_sync`: the written value becomes `div_act` in the same cycle and `pend` ends at 0.
  - Write to channel a coincident with a wrap on channel b≠a: the two are independent.
  - `i_rst` overrides everything, including a same-cycle write.
- Arithmetic: `cnt`+1 never overflows, because `cnt`≤`div_act`≤2^WIDTH−1 and the counter wraps at equality.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- After reset releases with `i_CE`=`i_ch_en`=1 and divisor D:
  - First `o_tick` is high in the cycle after the (D+1)th rising edge.
  - Subsequent ticks follow every D+1 enabled edges.
- `o_pending` rises one cycle after the `i_wr` edge and falls with the wrap that applies the write.
- The new period starts counting from the wrap that applies the write.
- A mid-operation `i_rst` or `i_sync` gives all `o_tick` low on the next cycle, and the count restarts from 0.

## Structure
- Shared package `divisor_pkg` holds:
  - `DIV_W_DEFAULT` (26)
  - `DIV_DEFAULT` (10_000_000)
  - `DIV_SIM` (4_096_000) for simulation builds
- Sub-module `divisor_channel` contains one channel's counter, shadow, wrap logic and outputs.
- The top level is a generate loop over CHANNELS plus write-address decode and `i_sync` fan-out.

## Test plan
- Reset, DEFAULT_DIV overridden to 4, CE=1, all enabled -> `o_tick` high in cycles 5, 10, 15, …, one cycle wide; `o_sq` period 10.
- D=0 written to ch0 while ch0 is disabled, then enabled -> `o_tick[0]` high every cycle; `o_pending[0]` is 0 after one cycle.
- D=9 running, write D=3 at `cnt`=5 -> `o_pending`=1 until the wrap at `cnt`=9; after that wrap the tick period is 4.
- Toggle `i_CE` low for 7 cycles mid-period with D=9 -> tick delayed by exactly 7 cycles; `o_tick` never high while CE=0.
- Channels at D=2, 3, 4, 6, pulse `i_sync` -> all `cnt`=0 and `sq`=0; ticks realign to the sync edge.
- Write to channel index CHANNELS (out of range) -> no state change; a write coincident with a wrap applies immediately with `o_pending` staying 0.

Source files
------------

// File: rtl/divisor_pkg.sv
// Shared constants and helpers for the multi-channel tick divider.
package divisor_pkg;
   localparam int DIV_W_DEFAULT = 26;
   localparam int DIV_DEFAULT   = 10_000_000;
   localparam int DIV_SIM       = 4_096_000;

   // Channel-select width, at least one bit even for a single channel.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/divisor_channel.sv
// One divider channel: counter, shadow/active divisor pair, wrap logic and
// registered tick, square-wave and pending outputs.
module divisor_channel
   import divisor_pkg::*;
#(
   parameter int               WIDTH       = DIV_W_DEFAULT,
   parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DIV_DEFAULT)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_ce,
   input  logic             i_en,
   input  logic             i_sync,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] i_wr_div,
   output logic             o_tick,
   output logic             o_sq,
   output logic             o_pending
);
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] act_q, act_d;
   logic [WIDTH-1:0] shd_q, shd_d;
   logic             pend_q, pend_d;
   logic             tick_q, tick_d;
   logic             sq_q, sq_d;
   logic             apply;

   always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      // A write in this cycle is folded in first so a coincident apply uses it.
      shd_d  = i_wr ? i_wr_div : shd_q;
      pend_d = pend_q | i_wr;
      tick_d = 1'b0;
      sq_d   = sq_q;
      apply  = 1'b0;
      if (i_sync || !i_en) begin
         cnt_d = '0;
         sq_d  = 1'b0;
         apply = 1'b1;
      end else if (i_ce) begin
         if (cnt_q == act_q) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            sq_d   = ~sq_q;
            apply  = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      if (apply && pend_d) begin
         act_d  = shd_d;
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q  <= '0;
         act_q  <= DEFAULT_DIV;
         shd_q  <= DEFAULT_DIV;
         pend_q <= 1'b0;
         tick_q <= 1'b0;
         sq_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         act_q  <= act_d;
         shd_q  <= shd_d;
         pend_q <= pend_d;
         tick_q <= tick_d;
         sq_q   <= sq_d;
      end
   end

   assign o_tick    = tick_q;
   assign o_sq      = sq_q;
   assign o_pending = pend_q;
endmodule

// File: rtl/divisor_multi.sv
// Multi-channel clock-enable tick generator: write-address decode, sync
// fan-out and one divisor_channel per channel.
module divisor_multi
   import divisor_pkg::*;
#(
   parameter int WIDTH       = DIV_W_DEFAULT,
   parameter int CHANNELS    = 4,
   parameter int DEFAULT_DIV = DIV_DEFAULT
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_CE,
   input  logic [CHANNELS-1:0]          i_ch_en,
   input  logic                         i_sync,
   input  logic                         i_wr,
   input  logic [idx_w(CHANNELS)-1:0]   i_wr_ch,
   input  logic [WIDTH-1:0]             i_wr_div,
   output logic [CHANNELS-1:0]          o_tick,
   output logic [CHANNELS-1:0]          o_sq,
   output logic [CHANNELS-1:0]          o_pending
);
   localparam int CH_W = idx_w(CHANNELS);

   logic [CHANNELS-1:0] wr_hit;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
         // Unused select codes at or above CHANNELS match no channel.
         localparam logic [CH_W-1:0] IDX = CH_W'(gi);

         assign wr_hit[gi] = i_wr && (i_wr_ch == IDX);

         divisor_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (WIDTH'(DEFAULT_DIV))
         ) u_ch (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_ce      (i_CE),
            .i_en      (i_ch_en[gi]),
            .i_sync    (i_sync),
            .i_wr      (wr_hit[gi]),
            .i_wr_div  (i_wr_div),
            .o_tick    (o_tick[gi]),
            .o_sq      (o_sq[gi]),
            .o_pending (o_pending[gi])
         );
      end
   endgenerate
endmodule

// File: tb/tb_divisor_multi.sv
// Directed and randomized bench for divisor_multi with a per-cycle reference model.
module tb_divisor_multi;
   localparam int CH = 5;
   localparam int W  = 8;
   localparam int DD = 4;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst, ce, sync, wr;
   logic [CH-1:0] en;
   logic [CW-1:0] wr_ch;
   logic [W-1:0]  wr_div;
   logic [CH-1:0] o_tick, o_sq, o_pending;

   int checks = 0;
   int errors = 0;

   int m_cnt [CH];
   int m_act [CH];
   int m_shd [CH];
   bit m_pend[CH];
   bit m_tick[CH];
   bit m_sq  [CH];

   always #5 clk = ~clk;

   divisor_multi #(.WIDTH(W), .CHANNELS(CH), .DEFAULT_DIV(DD)) dut (
      .i_clk(clk), .i_rst(rst), .i_CE(ce), .i_ch_en(en), .i_sync(sync),
      .i_wr(wr), .i_wr_ch(wr_ch), .i_wr_div(wr_div),
      .o_tick(o_tick), .o_sq(o_sq), .o_pending(o_pending)
   );

   // Reference: applies the divider rules to the inputs present at an edge.
   task automatic model_step();
      for (int c = 0; c < CH; c++) begin
         bit hit;
         int shd_n;
         bit pend_n;
         bit apply;
         hit    = wr && (int'(wr_ch) == c);
         shd_n  = hit ? int'(wr_div) : m_shd[c];
         pend_n = m_pend[c] || hit;
         apply  = 1'b0;
         if (rst) begin
            m_cnt[c] = 0; m_act[c] = DD; m_shd[c] = DD;
            m_pend[c] = 0; m_tick[c] = 0; m_sq[c] = 0;
            continue;
         end
         m_tick[c] = 0;
         if (sync || !en[c]) begin
            m_cnt[c] = 0; m_sq[c] = 0; apply = 1;
         end else if (ce) begin
            if (m_cnt[c] == m_act[c]) begin
               m_cnt[c] = 0; m_tick[c] = 1; m_sq[c] = !m_sq[c]; apply = 1;
            end else begin
               m_cnt[c] = m_cnt[c] + 1;
            end
         end
         m_shd[c] = shd_n;
         if (apply && pend_n) begin
            m_act[c] = shd_n;
            pend_n   = 0;
         end
         m_pend[c] = pend_n;
      end
   endtask

   task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      logic [CH-1:0] et, es, ep;
      @(posedge clk);
      model_step();
      #1;
      for (int c = 0; c < CH; c++) begin
         et[c] = m_tick[c]; es[c] = m_sq[c]; ep[c] = m_pend[c];
      end
      chk("model_tick", o_tick, et);
      chk("model_sq", o_sq, es);
      chk("model_pending", o_pending, ep);
   endtask

   task automatic write_cyc(input int ch, input int d);
      wr = 1'b1; wr_ch = CW'(ch); wr_div = W'(d);
      $display("write ch=%0d div=%0d", ch, d);
      cyc();
      wr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ce = 1'b0; en = '0; sync = 1'b0; wr = 1'b0; wr_ch = '0; wr_div = '0;
      for (int c = 0; c < CH; c++) begin
         m_cnt[c] = 0; m_act[c] = DD; m_shd[c] = DD; m_pend[c] = 0; m_tick[c] = 0; m_sq[c] = 0;
      end
      #2;
      cyc(); cyc();
      chk("reset_tick", o_tick, '0);
      chk("reset_sq", o_sq, '0);
      chk("reset_pending", o_pending, '0);

      // Default divisor 4: ticks at 5, 10, 15, 20; square wave period 10.
      rst = 1'b0; ce = 1'b1; en = '1;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         chk("dflt_tick", o_tick, (k % 5 == 0) ? {CH{1'b1}} : {CH{1'b0}});
         chk("dflt_sq", o_sq, (((k / 5) % 2) == 1) ? {CH{1'b1}} : {CH{1'b0}});
      end

      // D=0 written to a disabled channel 0, then enabled.
      en[0] = 1'b0;
      write_cyc(0, 0);
      en[0] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cyc();
         chk("d0_tick", {4'b0, o_tick[0]}, 5'b00001);
         chk("d0_pend", {4'b0, o_pending[0]}, 5'b00000);
      end

      // Channel 1 at D=9, then a mid-period write of D=3 at cnt=5.
      write_cyc(1, 9);
      sync = 1'b1; cyc(); sync = 1'b0;
      for (int k = 0; k < 5; k++) cyc();
      write_cyc(1, 3);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("stage_pend", {4'b0, o_pending[1]}, 5'b00001);
      end
      cyc();
      chk("stage_wrap_tick", {4'b0, o_tick[1]}, 5'b00001);
      chk("stage_wrap_pend", {4'b0, o_pending[1]}, 5'b00000);
      for (int k = 1; k <= 8; k++) begin
         cyc();
         chk("new_period", {4'b0, o_tick[1]}, (k % 4 == 0) ? 5'b00001 : 5'b00000);
      end

      // CE held low for 7 cycles mid-period.
      for (int k = 0; k < 2; k++) cyc();
      ce = 1'b0;
      for (int k = 0; k < 7; k++) begin
         cyc();
         chk("ce_low_tick", o_tick, '0);
      end
      ce = 1'b1;
      for (int k = 0; k < 12; k++) cyc();

      // Channels 1..4 at D=2,3,4,6 realigned by a sync pulse.
      write_cyc(1, 2); write_cyc(2, 3); write_cyc(3, 4); write_cyc(4, 6);
      sync = 1'b1; cyc(); sync = 1'b0;
      chk("sync_tick", o_tick, '0);
      chk("sync_sq", o_sq, '0);
      chk("sync_pend", o_pending, '0);
      for (int k = 1; k <= 30; k++) begin
         logic [CH-1:0] et;
         cyc();
         et = {(k % 7 == 0), (k % 5 == 0), (k % 4 == 0), (k % 3 == 0), 1'b1};
         chk("sync_align", o_tick, et);
      end

      // Out-of-range channel writes must change nothing.
      write_cyc(5, 1); write_cyc(6, 1); write_cyc(7, 1);
      chk("oor_pend", o_pending, '0);
      for (int k = 0; k < 10; k++) cyc();

      // Write coincident with channel 2 wrap.
      for (int k = 0; k < 10 && m_cnt[2] != m_act[2]; k++) cyc();
      write_cyc(2, 7);
      chk("coinc_pend", {4'b0, o_pending[2]}, 5'b00000);
      chk("coinc_tick", {4'b0, o_tick[2]}, 5'b00001);
      for (int k = 0; k < 16; k++) cyc();

      // Randomized traffic against the model.
      for (int k = 0; k < 600; k++) begin
         rst  = ($urandom_range(0, 199) == 0);
         sync = ($urandom_range(0, 59) == 0);
         ce   = ($urandom_range(0, 9) != 0);
         for (int c = 0; c < CH; c++) en[c] = ($urandom_range(0, 19) != 0);
         wr     = ($urandom_range(0, 5) == 0);
         wr_ch  = CW'($urandom_range(0, 7));
         wr_div = W'($urandom_range(0, 12));
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
